// File: rtl/poci_uart.sv
// poci_uart: 8N1 UART slave on the POCI bus. It has an 8-entry FIFO per direction
// and a programmable clocks-per-bit divisor.
module poci_uart_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] head,
  output logic       empty,
  output logic       full,
  output logic       ovf
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  // Pop on empty is ignored; push on full is accepted only when a pop frees the slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign ovf     = push && !do_push;
  assign head    = mem[rptr];

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= wdata;
endmodule

module poci_uart #(
  parameter int CLK_HZ = 24_000_000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [3:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        txd,
  input  logic        rxd
);
  localparam logic [15:0] DIV_RST = 16'(CLK_HZ / BAUD);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} st_t;

  logic       wr, rd, st_wr;
  logic [1:0] addr;
  logic       unused_bits;
  assign addr        = paddr[3:2];
  assign wr          = psel & penable & pwrite;
  assign rd          = psel & penable & ~pwrite;
  assign st_wr       = wr && addr == 2'd1;
  assign pready      = 1'b1;
  assign unused_bits = ^{pwdata[31:16], paddr[1:0]};

  logic [15:0] div_q;
  logic        tx_ovf, rx_ovr, rx_fe;
  logic        tx_push, tx_pop, tx_empty, tx_full, tx_ovf_ev;
  logic        rx_push, rx_pop, rx_empty, rx_full, rx_ovf_ev, rx_fe_set;
  logic [7:0]  tx_head, rx_head, rx_sh;

  assign tx_push = wr && addr == 2'd0;
  assign rx_pop  = rd && addr == 2'd0;

  poci_uart_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop), .wdata(pwdata[7:0]),
    .head(tx_head), .empty(tx_empty), .full(tx_full), .ovf(tx_ovf_ev));

  poci_uart_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop), .wdata(rx_sh),
    .head(rx_head), .empty(rx_empty), .full(rx_full), .ovf(rx_ovf_ev));

  // ---------------- TX ----------------
  st_t         tx_st, tx_nx;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_sh;
  logic        txd_q, txd_nx, tx_exp, tx_reload, tx_shift, tx_idle;

  assign tx_exp  = (tx_cnt == '0);
  assign tx_idle = tx_empty && tx_st == S_IDLE;
  assign txd     = txd_q;

  always_comb begin
    tx_nx = tx_st; tx_pop = 1'b0; tx_reload = 1'b0; tx_shift = 1'b0;
    case (tx_st)
      S_IDLE:  if (!tx_empty) begin tx_nx = S_START; tx_pop = 1'b1; tx_reload = 1'b1; end
      S_START: if (tx_exp) begin tx_nx = S_DATA; tx_reload = 1'b1; end
      S_DATA:  if (tx_exp) begin
                 tx_reload = 1'b1; tx_shift = 1'b1;
                 if (tx_bit == 3'd7) tx_nx = S_STOP;
               end
      S_STOP:  if (tx_exp) begin
                 tx_reload = 1'b1;
                 if (!tx_empty) begin tx_nx = S_START; tx_pop = 1'b1; end
                 else tx_nx = S_IDLE;
               end
      default: tx_nx = S_IDLE;
    endcase
    // txd is registered from the next state so the pin never glitches
    case (tx_nx)
      S_START: txd_nx = 1'b0;
      S_DATA:  txd_nx = tx_shift ? tx_sh[1] : tx_sh[0];
      default: txd_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tx_st <= S_IDLE; tx_cnt <= '0; tx_bit <= '0; tx_sh <= '0; txd_q <= 1'b1;
    end else begin
      tx_st <= tx_nx;
      txd_q <= txd_nx;
      if (tx_reload)    tx_cnt <= div_q - 16'd1;
      else if (!tx_exp) tx_cnt <= tx_cnt - 16'd1;
      if (tx_pop) begin
        tx_sh <= tx_head; tx_bit <= '0;
      end else if (tx_shift) begin
        tx_sh <= {1'b0, tx_sh[7:1]}; tx_bit <= tx_bit + 3'd1;
      end
    end

  // ---------------- RX ----------------
  st_t         rx_st, rx_nx;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic        rx_m, rxs, rxs_d, rx_exp, rx_half, rx_reload, rx_sample;

  assign rx_exp = (rx_cnt == '0);

  always_comb begin
    rx_nx = rx_st; rx_half = 1'b0; rx_reload = 1'b0; rx_sample = 1'b0;
    rx_push = 1'b0; rx_fe_set = 1'b0;
    case (rx_st)
      S_IDLE:  if (rxs_d && !rxs) begin rx_nx = S_START; rx_half = 1'b1; end
      S_START: if (rx_exp) begin
                 if (rxs) rx_nx = S_IDLE;
                 else begin rx_nx = S_DATA; rx_reload = 1'b1; end
               end
      S_DATA:  if (rx_exp) begin
                 rx_sample = 1'b1; rx_reload = 1'b1;
                 if (rx_bit == 3'd7) rx_nx = S_STOP;
               end
      S_STOP:  if (rx_exp) begin rx_push = 1'b1; rx_fe_set = !rxs; rx_nx = S_IDLE; end
      default: rx_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rx_m <= 1'b1; rxs <= 1'b1; rxs_d <= 1'b1;
      rx_st <= S_IDLE; rx_cnt <= '0; rx_bit <= '0; rx_sh <= '0;
    end else begin
      rx_m  <= rxd;
      rxs   <= rx_m;
      rxs_d <= rxs;
      rx_st <= rx_nx;
      // Half-bit first wait centres every later sample in its bit
      if (rx_half)        rx_cnt <= {1'b0, div_q[15:1]} - 16'd1;
      else if (rx_reload) rx_cnt <= div_q - 16'd1;
      else if (!rx_exp)   rx_cnt <= rx_cnt - 16'd1;
      if (rx_half) rx_bit <= '0;
      else if (rx_sample) begin
        rx_sh <= {rxs, rx_sh[7:1]}; rx_bit <= rx_bit + 3'd1;
      end
    end

  // ---------------- registers ----------------
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      div_q <= DIV_RST; tx_ovf <= 1'b0; rx_ovr <= 1'b0; rx_fe <= 1'b0;
    end else begin
      if (wr && addr == 2'd2) div_q <= (pwdata[15:0] < 16'd4) ? 16'd4 : pwdata[15:0];
      tx_ovf <= tx_ovf_ev              | (tx_ovf & ~(st_wr & pwdata[6]));
      rx_fe  <= rx_fe_set              | (rx_fe  & ~(st_wr & pwdata[5]));
      rx_ovr <= (rx_push & rx_ovf_ev)  | (rx_ovr & ~(st_wr & pwdata[4]));
    end

  always_comb begin
    prdata = '0;
    if (rd)
      case (addr)
        2'd0:    prdata = {24'b0, rx_empty ? 8'h00 : rx_head};
        2'd1:    prdata = {25'b0, tx_ovf, rx_fe, rx_ovr, rx_full, !rx_empty, tx_idle, tx_full};
        2'd2:    prdata = {16'b0, div_q};
        default: prdata = '0;
      endcase
  end
endmodule

// File: tb/tb_poci_uart.sv
// Scoreboard bench for poci_uart. Bus reads and TX frames carry expectations in
// queues, and independent monitors pop those queues and compare the observed traffic against them.
module tb_poci_uart;
  logic        clk = 1'b0, reset = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [3:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready, txd, rxd;
  logic        rxd_drv = 1'b1, loop_en = 1'b0, tx_mon_en = 1'b1;
  int          checks = 0, failures = 0, cyc = 0, cur_div = 208;
  int          w;
  logic [9:0]  pat;
  string       name_q[$];
  logic [31:0] val_q[$];
  logic [7:0]  tx_q[$];

  localparam logic [3:0] A_DATA = 4'h0, A_STAT = 4'h4, A_DIV = 4'h8;

  assign rxd = loop_en ? txd : rxd_drv;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  poci_uart dut (
    .clk(clk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .txd(txd), .rxd(rxd));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) begin @(posedge clk); #1; end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    tick(1); penable = 1'b1;
    tick(1); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string nm);
    name_q.push_back(nm); val_q.push_back(exp);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    tick(1); penable = 1'b1;
    tick(1); psel = 1'b0; penable = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin rxd_drv = f[i]; tick(4); end
    rxd_drv = 1'b1;
  endtask

  // Read monitor: every read access consumes one expectation
  always begin : rd_mon
    @(negedge clk);
    if (!reset && psel && penable && !pwrite) begin
      if (val_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL rd_unexpected: got 0x%0h expected no read", prdata);
      end else check(name_q.pop_front(), prdata, val_q.pop_front());
    end
  end

  // TX monitor: decodes frames mid-bit and compares against queued bytes
  always begin : tx_mon
    logic [7:0] b;
    logic       stp;
    int         d;
    @(negedge clk);
    if (tx_mon_en && !reset && txd === 1'b0) begin
      d = cur_div;
      repeat (d / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin repeat (d) @(negedge clk); b[i] = txd; end
      repeat (d) @(negedge clk);
      stp = txd;
      check("tx_stop", {31'b0, stp}, 32'd1);
      if (tx_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL tx_unexpected: got 0x%0h expected no frame", b);
      end else check("tx_frame", {24'b0, b}, {24'b0, tx_q.pop_front()});
    end
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tick(3);
    reset = 1'b0;
    tick(1);
    // reset state
    check("rst_txd", {31'b0, txd}, 32'd1);
    check("rst_pready", {31'b0, pready}, 32'd1);
    check("rst_prdata", prdata, 32'd0);
    bus_read(A_STAT, 32'h02, "rst_status");
    bus_read(A_DIV, 32'd208, "rst_div");

    // 1: single TX byte at DIV=4
    bus_write(A_DIV, 32'd4); cur_div = 4;
    tx_q.push_back(8'hA5);
    bus_write(A_DATA, 32'hA5);
    w = cyc;
    pat = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 39; k++) begin
      wait_until(w + 1 + k);
      check($sformatf("tx_bit_c%0d", k), {31'b0, txd}, {31'b0, pat[k / 4]});
    end
    bus_read(A_STAT, 32'h00, "tx1_busy_last_cycle");
    bus_read(A_STAT, 32'h02, "tx1_idle");

    // 2: back-to-back, full and overflow
    for (int i = 0; i < 10; i++) begin
      if (i < 9) tx_q.push_back(8'(8'h10 + i));
      bus_write(A_DATA, 32'h10 + i);
      if (i == 0) w = cyc;
    end
    bus_read(A_STAT, 32'h41, "tx2_full_ovf");
    bus_write(A_STAT, 32'h40);
    bus_read(A_STAT, 32'h01, "tx2_ovf_clear");
    wait_until(w + 358);
    bus_read(A_STAT, 32'h00, "tx2_busy_end");
    bus_read(A_STAT, 32'h02, "tx2_idle_contig");

    // 3: loopback
    loop_en = 1'b1;
    tx_q.push_back(8'h3C);
    bus_write(A_DATA, 32'h3C);
    w = cyc;
    wait_until(w + 45);
    bus_read(A_STAT, 32'h06, "lb_rx_valid");
    bus_read(A_DATA, 32'h3C, "lb_data");
    bus_read(A_STAT, 32'h02, "lb_rx_empty");
    bus_read(A_DATA, 32'h00, "lb_empty_read");
    loop_en = 1'b0;
    tick(2);

    // 4: framing error, then glitch
    send_rx(8'h81, 1'b0);
    tick(8);
    bus_read(A_STAT, 32'h26, "fe_status");
    bus_read(A_DATA, 32'h81, "fe_data");
    bus_write(A_STAT, 32'h20);
    bus_read(A_STAT, 32'h02, "fe_clear");
    rxd_drv = 1'b0; tick(1); rxd_drv = 1'b1;
    tick(20);
    bus_read(A_STAT, 32'h02, "glitch_no_push");

    // 5: overrun
    for (int i = 0; i < 9; i++) send_rx(8'(8'h11 * (i + 1)), 1'b1);
    tick(10);
    bus_read(A_STAT, 32'h1E, "ovr_status");
    for (int i = 0; i < 8; i++)
      bus_read(A_DATA, 32'h11 * (i + 1), $sformatf("ovr_data%0d", i));
    bus_read(A_STAT, 32'h12, "ovr_sticky");
    bus_write(A_STAT, 32'h10);
    bus_read(A_STAT, 32'h02, "ovr_clear");

    // 6: reset mid-frame and DIV clamp
    tx_mon_en = 1'b0;
    bus_write(A_DATA, 32'h55);
    w = cyc;
    wait_until(w + 18);
    check("rst_mid_bit3", {31'b0, txd}, 32'd0);
    reset = 1'b1;
    #1;
    check("rst_async_txd", {31'b0, txd}, 32'd1);
    tick(2);
    reset = 1'b0;
    tick(1);
    bus_read(A_STAT, 32'h02, "rst2_status");
    bus_read(A_DIV, 32'd208, "rst2_div");
    bus_write(A_DIV, 32'd1);
    bus_read(A_DIV, 32'd4, "div_clamp1");
    bus_write(A_DIV, 32'd5);
    bus_read(A_DIV, 32'd5, "div_5");
    bus_read(4'hC, 32'd0, "reserved_reg");

    tick(4);
    check("tx_q_drained", 32'(tx_q.size()), 32'd0);
    check("rd_q_drained", 32'(val_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
